// File: rtl/pipe_stage_skid.sv
// pipe_stage_skid: registered valid/ready pipeline stage with a 2-entry skid buffer and flush.
// Head entry drives the outputs; the skid entry absorbs one beat when downstream stalls.
module pipe_stage_skid #(
   parameter int CTRL_W = 8,
   parameter int DATA_W = 128
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              valid_i,
   output logic              ready_o,
   input  logic [CTRL_W-1:0] ctrl_i,
   input  logic [DATA_W-1:0] data_i,
   input  logic              flush_i,
   output logic              valid_o,
   input  logic              ready_i,
   output logic [CTRL_W-1:0] ctrl_o,
   output logic [DATA_W-1:0] data_o,
   output logic [1:0]        count_o
);
   typedef enum logic [1:0] {EMPTY = 2'd0, BUSY = 2'd1, FULL = 2'd2} state_t;
   state_t state, state_nx;
   logic [CTRL_W-1:0] head_ctrl, skid_ctrl;
   logic [DATA_W-1:0] head_data, skid_data;
   logic accept, send;
   assign accept = valid_i & ready_o;
   assign send   = valid_o & ready_i;
   always_ff @(posedge clk_i)
      state <= !rst_i ? EMPTY : state_nx;
   always_comb begin
      state_nx = state;
      if (flush_i)
         state_nx = EMPTY;
      else
         case (state)
            EMPTY:   state_nx = accept ? BUSY : EMPTY;
            BUSY:    state_nx = (accept & !send) ? FULL : (!accept & send) ? EMPTY : BUSY;
            FULL:    state_nx = send ? BUSY : FULL;
            default: state_nx = EMPTY;
         endcase
   end
   always_comb begin
      valid_o = state != EMPTY;
      ready_o = state != FULL;
      count_o = state;
      ctrl_o  = valid_o ? head_ctrl : '0;
      data_o  = head_data;
   end
   // Data is deliberately left alone on flush; only ctrl must become a bubble.
   always_ff @(posedge clk_i) begin
      if (!rst_i) begin
         head_ctrl <= '0;
         head_data <= '0;
         skid_ctrl <= '0;
         skid_data <= '0;
      end else if (flush_i) begin
         head_ctrl <= '0;
         skid_ctrl <= '0;
      end else
         case (state)
            EMPTY: if (accept) begin
               head_ctrl <= ctrl_i;
               head_data <= data_i;
            end
            BUSY: if (accept & send) begin
               head_ctrl <= ctrl_i;
               head_data <= data_i;
            end else if (accept) begin
               skid_ctrl <= ctrl_i;
               skid_data <= data_i;
            end else if (send)
               head_ctrl <= '0;
            FULL: if (send) begin
               head_ctrl <= skid_ctrl;
               head_data <= skid_data;
            end
            default: ;
         endcase
   end
endmodule

// File: tb/tb_pipe_stage_skid.sv
// tb_pipe_stage_skid: directed scenarios plus a queue-model stress run for pipe_stage_skid.
module tb_pipe_stage_skid;
   localparam int CW = 8;
   localparam int DW = 128;
   logic clk_i = 0, rst_i = 0, valid_i = 0, flush_i = 0, ready_i = 0;
   logic [CW-1:0] ctrl_i = '0;
   logic [DW-1:0] data_i = '0;
   logic ready_o, valid_o;
   logic [CW-1:0] ctrl_o;
   logic [DW-1:0] data_o;
   logic [1:0] count_o;
   int errors = 0, checks = 0;

   pipe_stage_skid #(.CTRL_W(CW), .DATA_W(DW)) dut (
      .clk_i(clk_i), .rst_i(rst_i), .valid_i(valid_i), .ready_o(ready_o),
      .ctrl_i(ctrl_i), .data_i(data_i), .flush_i(flush_i), .valid_o(valid_o),
      .ready_i(ready_i), .ctrl_o(ctrl_o), .data_o(data_o), .count_o(count_o)
   );

   always #5 clk_i = ~clk_i;

   task automatic tick();
      @(posedge clk_i);
      #1;
   endtask

   task automatic drive(input logic v, input logic [CW-1:0] c, input logic [DW-1:0] d, input logic r);
      valid_i = v;
      ctrl_i  = c;
      data_i  = d;
      ready_i = r;
   endtask

   task automatic do_reset();
      rst_i = 0;
      flush_i = 0;
      drive(0, '0, '0, 0);
      tick();
      rst_i = 1;
   endtask

   task automatic test_reset();
      do_reset();
      checks += 5;
      if (valid_o !== 1'b0) begin errors++; $display("FAIL reset valid_o got %0b want 0", valid_o); end
      if (ready_o !== 1'b1) begin errors++; $display("FAIL reset ready_o got %0b want 1", ready_o); end
      if (count_o !== 2'd0) begin errors++; $display("FAIL reset count_o got %0d want 0", count_o); end
      if (ctrl_o !== '0) begin errors++; $display("FAIL reset ctrl_o got %h want 0", ctrl_o); end
      if (data_o !== '0) begin errors++; $display("FAIL reset data_o got %h want 0", data_o); end
   endtask

   task automatic test_passthrough();
      do_reset();
      for (int i = 1; i <= 5; i++) begin
         drive(1, 8'h21, DW'(i), 1);
         tick();
         checks += 4;
         if (valid_o !== 1'b1) begin errors++; $display("FAIL pass valid_o beat %0d got %0b want 1", i, valid_o); end
         if (data_o !== DW'(i)) begin errors++; $display("FAIL pass data_o beat %0d got %h want %h", i, data_o, DW'(i)); end
         if (count_o !== 2'd1) begin errors++; $display("FAIL pass count_o beat %0d got %0d want 1", i, count_o); end
         if (ctrl_o !== 8'h21) begin errors++; $display("FAIL pass ctrl_o beat %0d got %h want 21", i, ctrl_o); end
      end
      drive(0, '0, '0, 1);
      tick();
      checks++;
      if (valid_o !== 1'b0) begin errors++; $display("FAIL pass drain valid_o got %0b want 0", valid_o); end
   endtask

   task automatic test_backpressure();
      do_reset();
      drive(1, 8'h01, DW'('hA), 0);
      tick();
      drive(1, 8'h02, DW'('hB), 0);
      tick();
      checks += 3;
      if (count_o !== 2'd2) begin errors++; $display("FAIL bp count_o got %0d want 2", count_o); end
      if (ready_o !== 1'b0) begin errors++; $display("FAIL bp ready_o got %0b want 0", ready_o); end
      if (data_o !== DW'('hA)) begin errors++; $display("FAIL bp data_o got %h want a", data_o); end
      drive(1, 8'h03, DW'('hC), 0);
      tick();
      checks += 2;
      if (count_o !== 2'd2) begin errors++; $display("FAIL bp stall count_o got %0d want 2", count_o); end
      if (data_o !== DW'('hA) || ctrl_o !== 8'h01) begin errors++; $display("FAIL bp stall head got %h/%h want a/01", data_o, ctrl_o); end
      drive(0, '0, '0, 1);
      tick();
      checks += 3;
      if (data_o !== DW'('hB) || ctrl_o !== 8'h02) begin errors++; $display("FAIL bp second head got %h/%h want b/02", data_o, ctrl_o); end
      if (ready_o !== 1'b1) begin errors++; $display("FAIL bp ready_o recover got %0b want 1", ready_o); end
      if (count_o !== 2'd1) begin errors++; $display("FAIL bp count_o after send got %0d want 1", count_o); end
      tick();
      checks++;
      if (valid_o !== 1'b0 || count_o !== 2'd0) begin errors++; $display("FAIL bp end valid/count got %0b/%0d want 0/0", valid_o, count_o); end
   endtask

   task automatic test_flush_full();
      do_reset();
      drive(1, 8'h3F, DW'('hA), 0);
      tick();
      drive(1, 8'h3F, DW'('hB), 0);
      tick();
      drive(1, 8'h3F, DW'('hC), 0);
      flush_i = 1;
      tick();
      flush_i = 0;
      drive(0, '0, '0, 1);
      checks += 4;
      if (valid_o !== 1'b0) begin errors++; $display("FAIL flush valid_o got %0b want 0", valid_o); end
      if (ctrl_o !== '0) begin errors++; $display("FAIL flush ctrl_o got %h want 0", ctrl_o); end
      if (count_o !== 2'd0) begin errors++; $display("FAIL flush count_o got %0d want 0", count_o); end
      if (ready_o !== 1'b1) begin errors++; $display("FAIL flush ready_o got %0b want 1", ready_o); end
      for (int i = 0; i < 3; i++) begin
         tick();
         checks++;
         if (valid_o !== 1'b0) begin errors++; $display("FAIL flush leak cycle %0d valid_o got %0b want 0", i, valid_o); end
      end
   endtask

   task automatic test_bubble();
      do_reset();
      drive(1, 8'hFF, DW'('h7), 1);
      tick();
      checks++;
      if (valid_o !== 1'b1 || ctrl_o !== 8'hFF) begin errors++; $display("FAIL bubble beat valid/ctrl got %0b/%h want 1/ff", valid_o, ctrl_o); end
      drive(0, '0, '0, 1);
      tick();
      checks++;
      if (valid_o !== 1'b0 || ctrl_o !== 8'h00) begin errors++; $display("FAIL bubble valid/ctrl got %0b/%h want 0/00", valid_o, ctrl_o); end
   endtask

   task automatic test_reset_mid();
      do_reset();
      drive(1, 8'h11, DW'('h1), 0);
      tick();
      drive(1, 8'h22, DW'('h2), 0);
      tick();
      rst_i = 0;
      drive(1, 8'h33, DW'('hDD), 1);
      tick();
      rst_i = 1;
      drive(0, '0, '0, 1);
      checks += 5;
      if (valid_o !== 1'b0) begin errors++; $display("FAIL rstmid valid_o got %0b want 0", valid_o); end
      if (count_o !== 2'd0) begin errors++; $display("FAIL rstmid count_o got %0d want 0", count_o); end
      if (data_o !== '0) begin errors++; $display("FAIL rstmid data_o got %h want 0", data_o); end
      if (ctrl_o !== '0) begin errors++; $display("FAIL rstmid ctrl_o got %h want 0", ctrl_o); end
      if (ready_o !== 1'b1) begin errors++; $display("FAIL rstmid ready_o got %0b want 1", ready_o); end
      tick();
      checks++;
      if (valid_o !== 1'b0) begin errors++; $display("FAIL rstmid capture valid_o got %0b want 0", valid_o); end
   endtask

   task automatic test_stress();
      logic [CW+DW-1:0] q[$];
      logic [CW+DW-1:0] beat;
      logic exp_v, m_acc, m_send;
      logic [CW-1:0] exp_c;
      logic [DW-1:0] exp_d, obs_d;
      int fails = 0;
      do_reset();
      for (int n = 0; n < 10000; n++) begin
         exp_v = q.size() != 0;
         exp_c = exp_v ? q[0][CW+DW-1:DW] : '0;
         exp_d = exp_v ? q[0][DW-1:0] : '0;
         obs_d = valid_o ? data_o : '0;
         checks++;
         if (valid_o !== exp_v || ready_o !== (q.size() < 2) || count_o !== 2'(q.size()) ||
             ctrl_o !== exp_c || obs_d !== exp_d) begin
            errors++;
            if (fails++ < 10)
               $display("FAIL stress cycle %0d v/r/n/c/d got %0b/%0b/%0d/%h/%h want %0b/%0b/%0d/%h/%h",
                        n, valid_o, ready_o, count_o, ctrl_o, obs_d, exp_v, q.size() < 2, q.size(), exp_c, exp_d);
         end
         beat = {CW'($urandom), $urandom, $urandom, $urandom, $urandom};
         drive($urandom_range(1), beat[CW+DW-1:DW], beat[DW-1:0], $urandom_range(3) != 0);
         flush_i = $urandom_range(99) < 2;
         m_acc  = valid_i && q.size() < 2;
         m_send = exp_v && ready_i;
         if (flush_i)
            q.delete();
         else begin
            if (m_send) void'(q.pop_front());
            if (m_acc) q.push_back(beat);
         end
         tick();
      end
      flush_i = 0;
   endtask

   initial begin
      test_reset();
      test_passthrough();
      test_backpressure();
      test_flush_full();
      test_bubble();
      test_reset_mid();
      test_stress();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
